// File: rtl/lcd_bus_receiver.sv
// Panel-side decoder for an 8080-style parallel LCD bus.
// Decodes DBI window/memory-write commands and emits addressed pixels.
module lcd_bus_receiver #(
    parameter int Width           = 32,
    parameter int Height          = 16,
    parameter int CoordinateWidth = 9,
    parameter int DataWidth       = 18,
    parameter int PixelWidth      = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [DataWidth-1:0]       lcd_db,
    input  logic                       lcd_wr,
    input  logic                       lcd_rd,
    input  logic                       lcd_rs,
    input  logic                       lcd_cs,
    input  logic                       lcd_rst,
    output logic [CoordinateWidth-1:0] out_x,
    output logic [CoordinateWidth-1:0] out_y,
    output logic [PixelWidth-1:0]      out_p,
    output logic                       out_valid,
    output logic [7:0]                 cmd,
    output logic                       cmd_valid,
    output logic                       frame_done,
    output logic                       window_error
);
    localparam int CW = CoordinateWidth;
    localparam logic [CW-1:0] EcRst = CW'(Width - 1);
    localparam logic [CW-1:0] EpRst = CW'(Height - 1);

    typedef enum logic [1:0] {IDLE, CASET, PASET, RAMWR} state_t;

    state_t          state_q, state_d;
    logic            wr_prev;
    logic [1:0]      pidx_q, pidx_d;
    logic [7:0]      s_hi_q, s_hi_d, s_lo_q, s_lo_d, e_hi_q, e_hi_d;
    logic [CW-1:0]   sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d;
    logic [CW-1:0]   out_x_d, out_y_d;
    logic [PixelWidth-1:0] out_p_d;
    logic [7:0]      cmd_d;
    logic            out_valid_d, cmd_valid_d, frame_done_d, window_error_d;
    logic            ev, rst;
    logic [15:0]     start16, end16, limit16;
    logic            win_ok;
    logic            unused;

    assign unused = ^{lcd_rd, lcd_db[DataWidth-1:PixelWidth]};
    assign ev     = lcd_wr && !wr_prev && !lcd_cs;
    assign rst    = reset || !lcd_rst;

    // Window candidate: last parameter byte comes straight off the bus
    assign start16 = {s_hi_q, s_lo_q};
    assign end16   = {e_hi_q, lcd_db[7:0]};
    assign limit16 = (state_q == CASET) ? 16'(Width) : 16'(Height);
    assign win_ok  = (start16 <= end16) && (end16 < limit16);

    always_comb begin
        state_d        = state_q;
        pidx_d         = pidx_q;
        s_hi_d         = s_hi_q;
        s_lo_d         = s_lo_q;
        e_hi_d         = e_hi_q;
        sc_d           = sc_q;
        ec_d           = ec_q;
        sp_d           = sp_q;
        ep_d           = ep_q;
        x_d            = x_q;
        y_d            = y_q;
        out_x_d        = out_x;
        out_y_d        = out_y;
        out_p_d        = out_p;
        cmd_d          = cmd;
        out_valid_d    = 1'b0;
        cmd_valid_d    = 1'b0;
        frame_done_d   = 1'b0;
        window_error_d = 1'b0;
        if (ev && !lcd_rs) begin
            cmd_d       = lcd_db[7:0];
            cmd_valid_d = 1'b1;
            pidx_d      = 2'd0;
            state_d     = IDLE;
            case (lcd_db[7:0])
                8'h2A: state_d = CASET;
                8'h2B: state_d = PASET;
                8'h2C: begin
                    state_d = RAMWR;
                    x_d     = sc_q;
                    y_d     = sp_q;
                end
                8'h3C: state_d = RAMWR;
                8'h01: begin
                    sc_d = '0;
                    ec_d = EcRst;
                    sp_d = '0;
                    ep_d = EpRst;
                    x_d  = '0;
                    y_d  = '0;
                end
                default: ;
            endcase
        end else if (ev) begin
            unique case (state_q)
                CASET, PASET: begin
                    pidx_d = pidx_q + 2'd1;
                    unique case (pidx_q)
                        2'd0: s_hi_d = lcd_db[7:0];
                        2'd1: s_lo_d = lcd_db[7:0];
                        2'd2: e_hi_d = lcd_db[7:0];
                        2'd3: begin
                            state_d = IDLE;
                            if (!win_ok) begin
                                window_error_d = 1'b1;
                            end else if (state_q == CASET) begin
                                sc_d = start16[CW-1:0];
                                ec_d = end16[CW-1:0];
                            end else begin
                                sp_d = start16[CW-1:0];
                                ep_d = end16[CW-1:0];
                            end
                        end
                    endcase
                end
                RAMWR: begin
                    out_x_d      = x_q;
                    out_y_d      = y_q;
                    out_p_d      = lcd_db[PixelWidth-1:0];
                    out_valid_d  = 1'b1;
                    frame_done_d = (x_q == ec_q) && (y_q == ep_q);
                    if (x_q == ec_q) begin
                        x_d = sc_q;
                        y_d = (y_q == ep_q) ? sp_q : y_q + CW'(1);
                    end else begin
                        x_d = x_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Edge tracking keeps running through panel reset so a held strobe
    // does not look like a fresh edge afterwards
    always_ff @(posedge clock) begin
        wr_prev <= reset ? 1'b1 : lcd_wr;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= IDLE;
            pidx_q       <= 2'd0;
            s_hi_q       <= '0;
            s_lo_q       <= '0;
            e_hi_q       <= '0;
            sc_q         <= '0;
            ec_q         <= EcRst;
            sp_q         <= '0;
            ep_q         <= EpRst;
            x_q          <= '0;
            y_q          <= '0;
            out_x        <= '0;
            out_y        <= '0;
            out_p        <= '0;
            cmd          <= '0;
            out_valid    <= 1'b0;
            cmd_valid    <= 1'b0;
            frame_done   <= 1'b0;
            window_error <= 1'b0;
        end else begin
            state_q      <= state_d;
            pidx_q       <= pidx_d;
            s_hi_q       <= s_hi_d;
            s_lo_q       <= s_lo_d;
            e_hi_q       <= e_hi_d;
            sc_q         <= sc_d;
            ec_q         <= ec_d;
            sp_q         <= sp_d;
            ep_q         <= ep_d;
            x_q          <= x_d;
            y_q          <= y_d;
            out_x        <= out_x_d;
            out_y        <= out_y_d;
            out_p        <= out_p_d;
            cmd          <= cmd_d;
            out_valid    <= out_valid_d;
            cmd_valid    <= cmd_valid_d;
            frame_done   <= frame_done_d;
            window_error <= window_error_d;
        end
    end
endmodule
